// File: rtl/iob_wb_pkg.sv
// Shared definitions for the IOb to Wishbone-B4 burst bridge.
// Contents:
//   CTI_* / BTE_*  Wishbone B4 cycle type and burst type encodings
//   state_t        bridge FSM states
//   beat_cti()     picks the CTI code for a beat from its position in the burst
package iob_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FLUSH
  } state_t;

  // A single-beat transfer is a classic cycle. Inside a burst every beat
  // announces an incrementing burst except the last one, which ends it.
  function automatic logic [2:0] beat_cti(input logic single_beat, input logic last_beat);
    if (single_beat)
      return CTI_CLASSIC;
    else if (last_beat)
      return CTI_EOB;
    else
      return CTI_INCR;
  endfunction

endpackage

// File: rtl/iob_wb_timeout.sv
// Ack timeout counter for the IOb to Wishbone bridge.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   clr_i     holds the count at zero; held while stb is low, so the count
//             restarts from zero on every stb rising edge
//   en_i      count one cycle; the bridge drives this with stb
//   expire_o  the count reached TIMEOUT while enabled (never for TIMEOUT=0)
module iob_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // TIMEOUT=0 would give a zero-width counter; one bit keeps it legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Count the cycles stb has been waiting; saturate at the limit so a
  // stalled slave cannot wrap the counter back to a small value.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)
      cnt <= '0;
    else if (en_i && (cnt != LIMIT))
      cnt <= cnt + 1'b1;
  end

  assign expire_o = (TIMEOUT != 0) && en_i && (cnt == LIMIT);

endmodule

// File: rtl/iob_iob2wishbone_burst.sv
// IOb master to Wishbone-B4 master bridge with incrementing bursts.
// Ports:
//   clk_i, wb_rst_i        clock, synchronous active-high reset
//   m_valid/m_addr/m_wdata/m_wstrb/m_len   IOb beat request (addr and len
//                          taken from the first beat only)
//   m_rdata/m_ready/m_err  registered beat completion, ready is a 1-cycle pulse
//   tout_o, stat_clr_i     sticky timeout flag and its clear
//   m_wb_*                 Wishbone B4 master (cyc/stb/adr/sel/we/dat/cti/bte)
module iob_iob2wishbone_burst
  import iob_wb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8,
  parameter int TIMEOUT   = 255,
  localparam int SEL_W    = DATA_W / 8,
  localparam int LEN_W    = $clog2(BURST_MAX)
) (
  input  logic              clk_i,
  input  logic              wb_rst_i,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [SEL_W-1:0]  m_wstrb,
  input  logic [LEN_W-1:0]  m_len,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_ready,
  output logic              m_err,
  output logic              tout_o,
  input  logic              stat_clr_i,
  output logic [ADDR_W-1:0] m_wb_adr_o,
  output logic [SEL_W-1:0]  m_wb_sel_o,
  output logic              m_wb_we_o,
  output logic [DATA_W-1:0] m_wb_dat_o,
  output logic              m_wb_cyc_o,
  output logic              m_wb_stb_o,
  output logic [2:0]        m_wb_cti_o,
  output logic [1:0]        m_wb_bte_o,
  input  logic [DATA_W-1:0] m_wb_dat_i,
  input  logic              m_wb_ack_i,
  input  logic              m_wb_err_i
);

  localparam logic [ADDR_W-1:0] ADR_MASK = ~ADDR_W'(SEL_W - 1);
  localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(SEL_W);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             beat_in;
  logic             last_beat;
  logic             tmo_expire;
  logic             abort;

  // While m_ready pulses the master is still showing the beat that just
  // completed, so m_valid only counts as a new beat in the following cycle.
  assign beat_in   = m_valid && !m_ready;
  assign last_beat = (cnt == len_q);
  assign abort     = m_wb_err_i || tmo_expire;

  iob_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (!m_wb_stb_o),
    .en_i     (m_wb_stb_o),
    .expire_o (tmo_expire)
  );

  // Bridge FSM. IDLE opens the cycle with the first beat, WAIT holds stb
  // until the slave answers, REQ keeps cyc asserted (B4 wait state) until the
  // master offers the next beat, FLUSH answers the remaining beats of an
  // aborted burst with errors and no bus activity.
  always_ff @(posedge clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      m_rdata    <= '0;
      m_ready    <= 1'b0;
      m_err      <= 1'b0;
      m_wb_adr_o <= '0;
      m_wb_sel_o <= '0;
      m_wb_we_o  <= 1'b0;
      m_wb_dat_o <= '0;
      m_wb_cyc_o <= 1'b0;
      m_wb_stb_o <= 1'b0;
      m_wb_cti_o <= CTI_CLASSIC;
      m_wb_bte_o <= '0;
    end else begin
      m_ready    <= 1'b0;
      m_err      <= 1'b0;
      m_wb_bte_o <= BTE_LINEAR;
      case (state)
        ST_IDLE: begin
          if (beat_in) begin
            m_wb_adr_o <= m_addr & ADR_MASK;
            len_q      <= m_len;
            cnt        <= '0;
            m_wb_we_o  <= |m_wstrb;
            m_wb_sel_o <= (|m_wstrb) ? m_wstrb : '1;
            m_wb_dat_o <= m_wdata;
            m_wb_cti_o <= beat_cti(m_len == '0, m_len == '0);
            m_wb_cyc_o <= 1'b1;
            m_wb_stb_o <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        ST_REQ: begin
          if (beat_in) begin
            m_wb_dat_o <= m_wdata;
            m_wb_sel_o <= m_wb_we_o ? m_wstrb : '1;
            m_wb_cti_o <= beat_cti(len_q == '0, last_beat);
            m_wb_stb_o <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            m_ready    <= 1'b1;
            m_err      <= 1'b1;
            m_rdata    <= '0;
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            m_wb_cti_o <= CTI_CLASSIC;
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= ST_FLUSH;
            end
          end else if (m_wb_ack_i) begin
            m_ready    <= 1'b1;
            m_rdata    <= m_wb_dat_i;
            m_wb_stb_o <= 1'b0;
            m_wb_adr_o <= m_wb_adr_o + ADR_STEP;
            if (last_beat) begin
              m_wb_cyc_o <= 1'b0;
              m_wb_cti_o <= CTI_CLASSIC;
              state      <= ST_IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= ST_REQ;
            end
          end
        end
        ST_FLUSH: begin
          if (beat_in) begin
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= '0;
            if (last_beat)
              state <= ST_IDLE;
            else
              cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky timeout flag; a new timeout wins over a clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (wb_rst_i)
      tout_o <= 1'b0;
    else if ((state == ST_WAIT) && tmo_expire)
      tout_o <= 1'b1;
    else if (stat_clr_i)
      tout_o <= 1'b0;
  end

endmodule

// File: tb/tb_iob_iob2wishbone_burst.sv
// Self-checking bench for iob_iob2wishbone_burst: table of bursts driven
// through a slave model with a scoreboard, plus hand sequences for timeout,
// reset in mid-burst and 16-bit address wrap.
module tb_iob_iob2wishbone_burst;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_len;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        m_err;
  logic        tout_o;
  logic        stat_clr;
  logic [31:0] m_wb_adr_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_we_o;
  logic [31:0] m_wb_dat_o;
  logic        m_wb_cyc_o;
  logic        m_wb_stb_o;
  logic [2:0]  m_wb_cti_o;
  logic [1:0]  m_wb_bte_o;
  logic [31:0] m_wb_dat_i;
  logic        m_wb_ack_i;
  logic        m_wb_err_i;

  always #5 clk = ~clk;

  iob_iob2wishbone_burst #(
    .ADDR_W(32), .DATA_W(32), .BURST_MAX(8), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .wb_rst_i(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_len(m_len),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .tout_o(tout_o), .stat_clr_i(stat_clr),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o), .m_wb_dat_o(m_wb_dat_o),
    .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o),
    .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i)
  );

  // Second instance with a 16-bit address bus for the wrap-around case.
  logic        v16;
  logic [15:0] a16;
  logic [31:0] wd16;
  logic [3:0]  ws16;
  logic [2:0]  len16;
  logic [31:0] rdata16;
  logic        ready16, err16, tout16;
  logic [15:0] adr16;
  logic [3:0]  sel16;
  logic        we16, cyc16, stb16, ack16, werr16;
  logic [31:0] dat16o, dat16i;
  logic [2:0]  cti16;
  logic [1:0]  bte16;

  iob_iob2wishbone_burst #(
    .ADDR_W(16), .DATA_W(32), .BURST_MAX(8), .TIMEOUT(TMO)
  ) dut16 (
    .clk_i(clk), .wb_rst_i(rst),
    .m_valid(v16), .m_addr(a16), .m_wdata(wd16), .m_wstrb(ws16), .m_len(len16),
    .m_rdata(rdata16), .m_ready(ready16), .m_err(err16),
    .tout_o(tout16), .stat_clr_i(stat_clr),
    .m_wb_adr_o(adr16), .m_wb_sel_o(sel16), .m_wb_we_o(we16), .m_wb_dat_o(dat16o),
    .m_wb_cyc_o(cyc16), .m_wb_stb_o(stb16), .m_wb_cti_o(cti16), .m_wb_bte_o(bte16),
    .m_wb_dat_i(dat16i), .m_wb_ack_i(ack16), .m_wb_err_i(werr16)
  );

  // Zero-wait slave for the 16-bit instance.
  assign ack16  = cyc16 & stb16;
  assign dat16i = 32'h5A5A_0000 ^ {16'h0000, adr16};

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  len;
    logic [3:0]  wstrb;
    logic [31:0] wbase;
    int          ack_delay;
    int          err_beat;
    bit          silent;
    int          exp_err_beats;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [2:0]  cti;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk_rdata;
  } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];
  bus_t  mon_b;
  resp_t mon_r;

  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;
  bit mon_en   = 1'b0;
  logic stb_prev = 1'b0;
  int stb_run = 0;
  int last_stb_run = 0;

  // Slave model: acks after ack_delay stb cycles, answers err on beat
  // err_beat, stays silent when asked; read data is keyed on the address.
  int          ack_delay = 0;
  int          err_beat  = -1;
  bit          silent    = 1'b0;
  logic [31:0] rd_key;
  int          stb_age    = 0;
  int          slave_beat = 0;
  logic        slv_hit;

  assign slv_hit    = m_wb_cyc_o && m_wb_stb_o && !silent && (stb_age >= ack_delay);
  assign m_wb_err_i = slv_hit && (slave_beat == err_beat);
  assign m_wb_ack_i = slv_hit && !m_wb_err_i;
  assign m_wb_dat_i = rd_key ^ m_wb_adr_o;

  always @(posedge clk) begin
    stb_age <= m_wb_stb_o ? stb_age + 1 : 0;
    if (!m_wb_cyc_o)
      slave_beat <= 0;
    else if (m_wb_stb_o && (m_wb_ack_i || m_wb_err_i))
      slave_beat <= slave_beat + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    n_checks++;
    $display("[TB] FAIL %s: event missing or unexpected", name);
  endtask

  task automatic waitReady(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (m_ready) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: compare each stb rising edge and each ready pulse against the
  // scoreboard queues; also measure how long stb stays high.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_wb_stb_o && !stb_prev) begin
        if (bus_q.size() == 0) begin
          failNow("unexpected stb");
        end else begin
          mon_b = bus_q.pop_front();
          checkOutput("wb adr", m_wb_adr_o, mon_b.adr);
          checkOutput("wb we", m_wb_we_o, mon_b.we);
          checkOutput("wb sel", m_wb_sel_o, mon_b.sel);
          checkOutput("wb cti", m_wb_cti_o, mon_b.cti);
          checkOutput("wb cyc", m_wb_cyc_o, 1);
          checkOutput("wb bte", m_wb_bte_o, 0);
          if (mon_b.we)
            checkOutput("wb dat", m_wb_dat_o, mon_b.dat);
        end
      end
      if (m_ready) begin
        if (resp_q.size() == 0) begin
          failNow("unexpected ready");
        end else begin
          mon_r = resp_q.pop_front();
          checkOutput("m_err", m_err, mon_r.err);
          if (mon_r.chk_rdata)
            checkOutput("m_rdata", m_rdata, mon_r.rdata);
        end
        if (m_err)
          err_seen++;
      end
    end
    if (m_wb_stb_o)
      stb_run = stb_prev ? stb_run + 1 : 1;
    else if (stb_prev)
      last_stb_run = stb_run;
    stb_prev = m_wb_stb_o;
  end

  // Push the expected bus beats and responses for one burst, then drive its
  // beats as an IOb master would and check cyc after every completion.
  task automatic applyStimulus(input vec_t v);
    int          errs0;
    logic [31:0] a;
    bit          we;
    bit          seen;
    bit          berr;
    bus_t        bt;
    resp_t       rt;
    errs0     = err_seen;
    ack_delay = v.ack_delay;
    err_beat  = v.err_beat;
    silent    = v.silent;
    we        = |v.wstrb;
    a         = v.addr & ~32'h3;
    for (int b = 0; b <= int'(v.len); b++) begin
      berr = (v.err_beat >= 0) && (b >= v.err_beat);
      if ((v.err_beat < 0) || (b <= v.err_beat)) begin
        bt.adr = a;
        bt.we  = we;
        bt.sel = we ? v.wstrb : 4'hF;
        bt.dat = v.wbase + b;
        bt.cti = (v.len == 3'd0) ? 3'b000 : (b == int'(v.len)) ? 3'b111 : 3'b010;
        bus_q.push_back(bt);
      end
      rt.rdata     = berr ? 32'h0 : (rd_key ^ a);
      rt.err       = berr;
      rt.chk_rdata = !we || berr;
      resp_q.push_back(rt);
      a = a + 32'd4;
    end
    for (int b = 0; b <= int'(v.len); b++) begin
      m_valid = 1'b1;
      m_addr  = (b == 0) ? v.addr : 32'hBAD0_0000;
      m_len   = (b == 0) ? v.len : 3'd0;
      m_wdata = v.wbase + b;
      m_wstrb = v.wstrb;
      waitReady(64, seen);
      if (!seen) begin
        failNow("ready wait");
        break;
      end
      berr = (v.err_beat >= 0) && (b >= v.err_beat);
      checkOutput("cyc after ready", m_wb_cyc_o, (b < int'(v.len)) && !berr);
    end
    m_valid = 1'b0;
    m_wstrb = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("err beat count", err_seen - errs0, v.exp_err_beats);
    checkOutput("scoreboard drained", bus_q.size() + resp_q.size(), 0);
    bus_q.delete();
    resp_q.delete();
  endtask

  vec_t vecs[7];
  vec_t tv;

  initial begin
    bit seen;
    logic [15:0] exp16;

    vecs[0] = '{32'h0000_0100, 3'd0, 4'h0, 32'h0,  2, -1, 1'b0, 0};
    vecs[1] = '{32'h0000_1000, 3'd3, 4'hF, 32'h1,  0, -1, 1'b0, 0};
    vecs[2] = '{32'h0000_2000, 3'd3, 4'h0, 32'h0,  1,  1, 1'b0, 3};
    vecs[3] = '{32'h0000_3002, 3'd1, 4'h3, 32'hA0, 1, -1, 1'b0, 0};
    vecs[4] = '{32'h0000_0040, 3'd7, 4'h0, 32'h0,  0, -1, 1'b0, 0};
    vecs[5] = '{32'h0000_0500, 3'd2, 4'h0, 32'h0,  0,  0, 1'b0, 3};
    vecs[6] = '{32'h0000_6000, 3'd2, 4'hC, 32'h77, 0,  2, 1'b0, 1};

    rd_key   = 32'hDEADBEEF ^ 32'h0000_0100;
    rst      = 1'b1;
    m_valid  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    m_len    = '0;
    stat_clr = 1'b0;
    v16      = 1'b0;
    a16      = '0;
    wd16     = '0;
    ws16     = '0;
    len16    = '0;
    werr16   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cyc", m_wb_cyc_o, 0);
    checkOutput("reset stb", m_wb_stb_o, 0);
    checkOutput("reset ready", m_ready, 0);
    checkOutput("reset err", m_err, 0);
    checkOutput("reset tout", tout_o, 0);
    checkOutput("reset adr", m_wb_adr_o, 0);
    checkOutput("reset cti", m_wb_cti_o, 0);
    checkOutput("reset sel", m_wb_sel_o, 0);
    checkOutput("reset rdata", m_rdata, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i]);

    // Silent slave: stb holds for TMO+1 cycles (count 0..TMO), then error.
    tv = '{32'h0000_7000, 3'd0, 4'h0, 32'h0, 0, 0, 1'b1, 1};
    applyStimulus(tv);
    checkOutput("stb cycles before timeout", last_stb_run, TMO + 1);
    checkOutput("tout set", tout_o, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("tout sticky", tout_o, 1);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    checkOutput("tout cleared", tout_o, 0);
    silent = 1'b0;

    // Reset while beat 2 of a 4-beat read is waiting on the bus.
    mon_en    = 1'b0;
    ack_delay = 0;
    err_beat  = -1;
    m_valid   = 1'b1;
    m_addr    = 32'h0000_0700;
    m_len     = 3'd3;
    m_wstrb   = 4'h0;
    waitReady(16, seen);
    if (!seen)
      failNow("reset seq ready");
    checkOutput("reset seq beat0 rdata", m_rdata, rd_key ^ 32'h0000_0700);
    silent = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset seq stb up", m_wb_stb_o, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid-burst reset cyc", m_wb_cyc_o, 0);
    checkOutput("mid-burst reset stb", m_wb_stb_o, 0);
    checkOutput("mid-burst reset ready", m_ready, 0);
    rst     = 1'b0;
    m_valid = 1'b0;
    silent  = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tv = '{32'h0000_0800, 3'd0, 4'h0, 32'h0, 1, -1, 1'b0, 0};
    applyStimulus(tv);

    // 16-bit address bus: a 2-beat read at 0xFFFC wraps to 0x0000.
    v16   = 1'b1;
    a16   = 16'hFFFC;
    len16 = 3'd1;
    for (int beat = 0; beat < 2; beat++) begin
      exp16 = (beat == 0) ? 16'hFFFC : 16'h0000;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        if (stb16) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        failNow("wrap stb");
      end else begin
        checkOutput("wrap adr", adr16, exp16);
        checkOutput("wrap cti", cti16, (beat == 0) ? 3'b010 : 3'b111);
        checkOutput("wrap sel", sel16, 4'hF);
        checkOutput("wrap we", we16, 0);
      end
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        if (ready16) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        failNow("wrap ready");
      end else begin
        checkOutput("wrap rdata", rdata16, 32'h5A5A_0000 ^ {16'h0000, exp16});
        checkOutput("wrap err", err16, 0);
        checkOutput("wrap cyc", cyc16, beat == 0);
      end
    end
    v16 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("wrap tout", tout16, 0);
    checkOutput("wrap bte", bte16, 0);
    checkOutput("wrap dat_o", dat16o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
